// File: rtl/pc_gen_if.sv
// Fetch-PC bus between the PC generator and the IF stage / hazard / EX logic.
// The generator side uses the master modport; the consumer side uses slave.
interface pc_gen_if #(
   parameter int unsigned XLEN = 32
);
   logic            stall;
   logic            redir_valid;
   logic [XLEN-1:0] redir_target;
   logic            trap;
   logic            halt;
   logic            resume;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus;
   logic            pc_valid;
   logic            misalign;
   logic [XLEN-1:0] bad_addr;

   modport master (
      input  stall, redir_valid, redir_target, trap, halt, resume,
      output pc, pc_plus, pc_valid, misalign, bad_addr
   );

   modport slave (
      output stall, redir_valid, redir_target, trap, halt, resume,
      input  pc, pc_plus, pc_valid, misalign, bad_addr
   );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator for the IF stage: BOOT/RUN/HALT control with
// prioritised trap, redirect, halt, stall and sequential increment.
module pc_gen #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
   parameter int unsigned     INC          = 4,
   parameter int unsigned     ALIGN_BITS   = 2
) (
   input  logic     clk,
   input  logic     rst,
   pc_gen_if.master bus
);

   // ALIGN_BITS of 0 yields an all-zero mask, which disables the check.
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_HALT
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            pc_valid_q, pc_valid_d;
   logic            misalign_q, misalign_d;
   logic [XLEN-1:0] bad_addr_q, bad_addr_d;
   logic [XLEN-1:0] pc_plus;
   logic            target_misaligned;

   assign pc_plus           = pc_q + XLEN'(INC);
   assign target_misaligned = |(bus.redir_target & ALIGN_MASK);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      misalign_d = 1'b0;
      bad_addr_d = bad_addr_q;
      unique case (state_q)
         S_BOOT: state_d = S_RUN;
         S_RUN: begin
            if (bus.trap) begin
               pc_d = TRAP_VECTOR;
            end else if (bus.redir_valid && target_misaligned) begin
               pc_d       = TRAP_VECTOR;
               misalign_d = 1'b1;
               bad_addr_d = bus.redir_target;
            end else if (bus.redir_valid) begin
               pc_d = bus.redir_target;
            end else if (bus.halt) begin
               state_d = S_HALT;
            end else if (!bus.stall) begin
               pc_d = pc_plus;
            end
         end
         S_HALT: begin
            if (bus.trap) begin
               pc_d    = TRAP_VECTOR;
               state_d = S_RUN;
            end else if (bus.resume) begin
               state_d = S_RUN;
            end
         end
         default: state_d = S_BOOT;
      endcase
      // Valid is registered alongside the state so it tracks the entered state.
      pc_valid_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_BOOT;
         pc_q       <= RESET_VECTOR;
         pc_valid_q <= 1'b0;
         misalign_q <= 1'b0;
         bad_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_valid_q <= pc_valid_d;
         misalign_q <= misalign_d;
         bad_addr_q <= bad_addr_d;
      end
   end

   assign bus.pc       = pc_q;
   assign bus.pc_plus  = pc_plus;
   assign bus.pc_valid = pc_valid_q;
   assign bus.misalign = misalign_q;
   assign bus.bad_addr = bad_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// compared against a rule-level reference model of the fetch PC.
module tb_pc_gen;

   localparam logic [31:0]     RESET_VEC  = 32'h0000_0000;
   localparam logic [31:0]     TRAP_VEC   = 32'h0000_0100;
   localparam int unsigned     INC_B      = 4;
   localparam longint unsigned ALIGN_UNIT = 4;
   localparam longint unsigned PC_MOD     = 64'h1_0000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pc_gen_if #(.XLEN(32)) bus ();

   pc_gen #(
      .XLEN(32),
      .RESET_VECTOR(RESET_VEC),
      .TRAP_VECTOR(TRAP_VEC),
      .INC(INC_B),
      .ALIGN_BITS(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: mode 0 = boot bubble, 1 = running, 2 = halted.
   int          m_mode;
   logic [31:0] m_pc;
   logic [31:0] m_bad;
   logic        m_mis;

   task automatic model_reset();
      m_mode = 0;
      m_pc   = RESET_VEC;
      m_bad  = '0;
      m_mis  = 1'b0;
   endtask

   task automatic clear_inputs();
      bus.stall        = 1'b0;
      bus.redir_valid  = 1'b0;
      bus.redir_target = '0;
      bus.trap         = 1'b0;
      bus.halt         = 1'b0;
      bus.resume       = 1'b0;
   endtask

   // Advance one clock edge, apply the fetch rules to the model, settle.
   task automatic step();
      @(posedge clk);
      m_mis = 1'b0;
      if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (bus.trap) m_pc = TRAP_VEC;
         else if (bus.redir_valid && (64'(bus.redir_target) % ALIGN_UNIT) != 0) begin
            m_pc  = TRAP_VEC;
            m_mis = 1'b1;
            m_bad = bus.redir_target;
         end else if (bus.redir_valid) m_pc = bus.redir_target;
         else if (bus.halt) m_mode = 2;
         else if (!bus.stall) m_pc = 32'((64'(m_pc) + INC_B) % PC_MOD);
      end else begin
         if (bus.trap) begin
            m_pc   = TRAP_VEC;
            m_mode = 1;
         end else if (bus.resume) m_mode = 1;
      end
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      @(posedge clk);
      #1;
      vectors++; if (bus.pc !== RESET_VEC) begin miscompares++; $display("FAIL reset_pc got %h want %h", bus.pc, RESET_VEC); end
      vectors++; if (bus.pc_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus.pc_valid); end
      vectors++; if (bus.misalign !== 1'b0) begin miscompares++; $display("FAIL reset_misalign got %b want 0", bus.misalign); end
      vectors++; if (bus.bad_addr !== 32'h0) begin miscompares++; $display("FAIL reset_bad_addr got %h want 0", bus.bad_addr); end
      // Still held in reset across an edge.
      @(posedge clk);
      #1;
      vectors++; if (bus.pc_valid !== 1'b0) begin miscompares++; $display("FAIL reset_hold_valid got %b want 0", bus.pc_valid); end
   endtask

   task automatic test_boot_sequence();
      logic [31:0] exp_pc [5] = '{32'd0, 32'd0, 32'd4, 32'd8, 32'd12};
      logic        exp_v  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      rst = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         vectors++; if (bus.pc !== exp_pc[i]) begin miscompares++; $display("FAIL boot_pc[%0d] got %h want %h", i, bus.pc, exp_pc[i]); end
         vectors++; if (bus.pc_valid !== exp_v[i]) begin miscompares++; $display("FAIL boot_valid[%0d] got %b want %b", i, bus.pc_valid, exp_v[i]); end
      end
      vectors++; if (bus.pc_plus !== 32'd16) begin miscompares++; $display("FAIL boot_pc_plus got %h want 10", bus.pc_plus); end
   endtask

   task automatic test_stall_redirect();
      clear_inputs();
      bus.redir_valid = 1'b1; bus.redir_target = 32'h10;
      step();
      vectors++; if (bus.pc !== 32'h10) begin miscompares++; $display("FAIL stall_setup got %h want 10", bus.pc); end
      bus.redir_valid = 1'b0;
      bus.stall = 1'b1;
      step();
      vectors++; if (bus.pc !== 32'h10) begin miscompares++; $display("FAIL stall_hold got %h want 10", bus.pc); end
      bus.redir_valid = 1'b1; bus.redir_target = 32'h40;
      step();
      vectors++; if (bus.pc !== 32'h40) begin miscompares++; $display("FAIL stall_redirect got %h want 40", bus.pc); end
      bus.redir_valid = 1'b0;
      step();
      vectors++; if (bus.pc !== 32'h40) begin miscompares++; $display("FAIL stall_hold2 got %h want 40", bus.pc); end
      bus.stall = 1'b0;
      step();
      vectors++; if (bus.pc !== 32'h44) begin miscompares++; $display("FAIL stall_release got %h want 44", bus.pc); end
   endtask

   task automatic test_misalign();
      clear_inputs();
      bus.redir_valid = 1'b1; bus.redir_target = 32'h42;
      step();
      vectors++; if (bus.pc !== TRAP_VEC) begin miscompares++; $display("FAIL misalign_pc got %h want %h", bus.pc, TRAP_VEC); end
      vectors++; if (bus.misalign !== 1'b1) begin miscompares++; $display("FAIL misalign_pulse got %b want 1", bus.misalign); end
      vectors++; if (bus.bad_addr !== 32'h42) begin miscompares++; $display("FAIL misalign_bad got %h want 42", bus.bad_addr); end
      bus.trap = 1'b1; bus.redir_target = 32'h43;
      step();
      vectors++; if (bus.pc !== TRAP_VEC) begin miscompares++; $display("FAIL trap_wins_pc got %h want %h", bus.pc, TRAP_VEC); end
      vectors++; if (bus.misalign !== 1'b0) begin miscompares++; $display("FAIL trap_wins_misalign got %b want 0", bus.misalign); end
      vectors++; if (bus.bad_addr !== 32'h42) begin miscompares++; $display("FAIL trap_wins_bad got %h want 42", bus.bad_addr); end
      clear_inputs();
      step();
      vectors++; if (bus.pc !== 32'h104) begin miscompares++; $display("FAIL after_trap_pc got %h want 104", bus.pc); end
      vectors++; if (bus.misalign !== 1'b0) begin miscompares++; $display("FAIL misalign_clear got %b want 0", bus.misalign); end
   endtask

   task automatic test_halt();
      clear_inputs();
      bus.redir_valid = 1'b1; bus.redir_target = 32'h20;
      step();
      bus.redir_valid = 1'b0;
      bus.halt = 1'b1;
      step();
      vectors++; if (bus.pc_valid !== 1'b0) begin miscompares++; $display("FAIL halt_valid got %b want 0", bus.pc_valid); end
      vectors++; if (bus.pc !== 32'h20) begin miscompares++; $display("FAIL halt_pc got %h want 20", bus.pc); end
      bus.halt = 1'b0;
      bus.redir_valid = 1'b1; bus.redir_target = 32'h80; bus.stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         vectors++; if (bus.pc !== 32'h20 || bus.pc_valid !== 1'b0) begin miscompares++; $display("FAIL halt_ignore[%0d] got pc %h v %b want pc 20 v 0", i, bus.pc, bus.pc_valid); end
      end
      clear_inputs();
      bus.resume = 1'b1;
      step();
      vectors++; if (bus.pc !== 32'h20 || bus.pc_valid !== 1'b1) begin miscompares++; $display("FAIL resume got pc %h v %b want pc 20 v 1", bus.pc, bus.pc_valid); end
      bus.resume = 1'b0;
      step();
      vectors++; if (bus.pc !== 32'h24) begin miscompares++; $display("FAIL resume_inc got %h want 24", bus.pc); end
   endtask

   task automatic test_wrap();
      clear_inputs();
      bus.redir_valid = 1'b1; bus.redir_target = 32'hFFFF_FFFC;
      step();
      vectors++; if (bus.pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_top got %h want fffffffc", bus.pc); end
      vectors++; if (bus.pc_plus !== 32'h0) begin miscompares++; $display("FAIL wrap_pc_plus got %h want 0", bus.pc_plus); end
      bus.redir_valid = 1'b0;
      step();
      vectors++; if (bus.pc !== 32'h0) begin miscompares++; $display("FAIL wrap_zero got %h want 0", bus.pc); end
      step();
      vectors++; if (bus.pc !== 32'h4) begin miscompares++; $display("FAIL wrap_four got %h want 4", bus.pc); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bus.stall        = ($urandom_range(0, 3) == 0);
         bus.redir_valid  = ($urandom_range(0, 5) == 0);
         bus.redir_target = $urandom;
         if ($urandom_range(0, 1) == 0) bus.redir_target[1:0] = 2'b00;
         bus.trap         = ($urandom_range(0, 15) == 0);
         bus.halt         = ($urandom_range(0, 11) == 0);
         bus.resume       = ($urandom_range(0, 3) == 0);
         step();
         vectors++; if (bus.pc !== m_pc) begin miscompares++; $display("FAIL rand_pc[%0d] got %h want %h", i, bus.pc, m_pc); end
         vectors++; if (bus.pc_valid !== (m_mode == 1)) begin miscompares++; $display("FAIL rand_valid[%0d] got %b want %b", i, bus.pc_valid, (m_mode == 1)); end
         vectors++; if (bus.misalign !== m_mis) begin miscompares++; $display("FAIL rand_misalign[%0d] got %b want %b", i, bus.misalign, m_mis); end
         vectors++; if (bus.bad_addr !== m_bad) begin miscompares++; $display("FAIL rand_bad[%0d] got %h want %h", i, bus.bad_addr, m_bad); end
         vectors++; if (bus.pc_plus !== 32'((64'(m_pc) + INC_B) % PC_MOD)) begin miscompares++; $display("FAIL rand_pc_plus[%0d] got %h", i, bus.pc_plus); end
      end
   endtask

   task automatic test_async_reset();
      clear_inputs();
      // Leave halt from random traffic, then record a nonzero bad_addr.
      bus.resume = 1'b1;
      step();
      clear_inputs();
      bus.redir_valid = 1'b1; bus.redir_target = 32'h0000_0123;
      step();
      vectors++; if (bus.bad_addr !== 32'h123) begin miscompares++; $display("FAIL arst_setup_bad got %h want 123", bus.bad_addr); end
      clear_inputs();
      bus.halt = 1'b1;
      step();
      bus.halt = 1'b0;
      vectors++; if (bus.pc_valid !== 1'b0 || bus.pc !== TRAP_VEC) begin miscompares++; $display("FAIL arst_setup_halt got pc %h v %b want pc %h v 0", bus.pc, bus.pc_valid, TRAP_VEC); end
      #2;
      rst = 1'b1;
      #1;
      vectors++; if (bus.pc !== RESET_VEC) begin miscompares++; $display("FAIL arst_pc got %h want %h", bus.pc, RESET_VEC); end
      vectors++; if (bus.pc_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid got %b want 0", bus.pc_valid); end
      vectors++; if (bus.bad_addr !== 32'h0) begin miscompares++; $display("FAIL arst_bad got %h want 0", bus.bad_addr); end
      #1;
      rst = 1'b0;
      model_reset();
      step();
      step();
      vectors++; if (bus.pc !== 32'h4 || bus.pc_valid !== 1'b1) begin miscompares++; $display("FAIL arst_restart got pc %h v %b want pc 4 v 1", bus.pc, bus.pc_valid); end
   endtask

   initial begin
      test_reset();
      test_boot_sequence();
      test_stall_redirect();
      test_misalign();
      test_halt();
      test_wrap();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the pipelined RISC-V core, replacing the plain PC register at the head of the IF stage. It holds the fetch PC and drives a fetch-valid qualifier. Each cycle it chooses, by fixed priority, between trap entry, control-flow redirect, halt, stall and sequential increment. A BOOT/RUN/HALT state machine controls it, and it converts misaligned redirect targets into a trap while latching the offending address.

## Interface
- XLEN, 32: PC width in bits.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset (XLEN bits).
- TRAP_VECTOR, 32'h0000_0100: PC loaded on trap entry (XLEN bits).
- INC, 4: sequential increment in bytes.
- ALIGN_BITS, 2: low target bits that must be zero; 0 disables the misalignment check.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hold the PC (hazard unit).
- redir_valid  in  1  taken branch/jump from EX.
- redir_target  in  XLEN  redirect destination.
- trap  in  1  external exception/interrupt request.
- halt  in  1  request to enter HALT.
- resume  in  1  request to leave HALT.
- pc  out  XLEN  current fetch address (registered).
- pc_plus  out  XLEN  pc + INC (combinational, mod 2^XLEN).
- pc_valid  out  1  pc is a valid fetch this cycle (registered).
- misalign  out  1  one-cycle pulse: the misaligned redirect was converted to a trap.
- bad_addr  out  XLEN  last misaligned redirect target (registered).

## Operation
- States: BOOT, RUN, HALT.
- Reset values: pc=RESET_VECTOR, state=BOOT, pc_valid=0, misalign=0, bad_addr=0.
- BOOT: pc holds; all inputs are ignored; the state goes to RUN on the next edge. This gives a single-cycle bubble.
- RUN: per-edge priority, highest first:
  - trap → pc=TRAP_VECTOR.
  - redir_valid with aligned target → pc=redir_target.
  - redir_valid with misaligned target (redir_target[ALIGN_BITS-1:0]≠0) → pc=TRAP_VECTOR, misalign=1, bad_addr=redir_target.
  - halt → pc holds, state=HALT.
  - stall → pc holds.
  - otherwise → pc=pc+INC.
- Redirect and trap override stall. stall never blocks a control-flow change.
- When trap and a misaligned redirect coincide, trap wins. In that case misalign stays 0 and bad_addr is unchanged.
- HALT:
  - pc holds; pc_valid=0.
  - trap → pc=TRAP_VECTOR, state=RUN.
  - else resume → state=RUN, pc unchanged.
  - redir_valid, stall and halt are ignored.
- pc_valid is 1 in RUN, 0 in BOOT and HALT. It is registered with the state, so it is 1 in the cycle after the edge that enters RUN.
- Arithmetic is unsigned mod 2^XLEN. pc = 2^XLEN−INC increments to 0 without any flag.
- misalign is cleared on every edge where it is not re-set.

## Timing
- All state changes take effect on the edge after the inputs are sampled. pc is visible in the following cycle, so redirect-to-fetch latency is 1 cycle.
- After reset deassertion:
  - edge 1: BOOT→RUN.
  - From that cycle: pc=RESET_VECTOR, pc_valid=1.
  - edge 2: first increment.
- Asserting rst at any point, including mid-HALT or in the same cycle as a redirect, forces the reset values immediately without waiting for clk.
- The pc_plus combinational path depends only on pc. There is no input-to-output combinational path.

## Test plan
- Reset release, RESET_VECTOR=0, INC=4, no stall: pc sequence over cycles is 0 (pc_valid=0), 0 (pc_valid=1), 4, 8, 12.
- stall high for 3 cycles at pc=0x10, with redir_valid pulsed on the 2nd cycle with target 0x40 → pc 0x10, 0x10, then 0x40; after stall drops the sequence continues 0x44.
- Redirect to 0x42 (ALIGN_BITS=2) → next pc=0x100, misalign pulses 1 for exactly one cycle, bad_addr=0x42. Then trap together with a redirect to 0x43 → pc=0x100, misalign=0, bad_addr stays 0x42.
- halt at pc=0x20 → pc_valid=0 and pc=0x20 held while redir_valid to 0x80 is asserted. resume → pc_valid=1 with pc=0x20, then 0x24.
- XLEN=32, redirect to 0xFFFF_FFFC → next pcs 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- rst asserted asynchronously mid-HALT between edges → pc=RESET_VECTOR, pc_valid=0, bad_addr=0 before the next clk edge.
